// File: rtl/serial_rx_unit_if.sv
// Handshake and data bundle between a serial receiver and its controller.
interface serial_rx_unit_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Sin;
  logic             Clear;
  logic [WIDTH-1:0] Dout;
  logic             Busy;
  logic             Valid;

  modport master (output Start, Sin, Clear, input Dout, Busy, Valid);
  modport slave  (input Start, Sin, Clear, output Dout, Busy, Valid);
endinterface

// File: rtl/serial_rx_unit.sv
// Serial-in/parallel-out receiver: captures WIDTH bits LSB first after Start,
// then presents the word on Dout with Valid until Start is released.
module serial_rx_unit #(
  parameter int WIDTH = 8
) (
  input  logic            Clk,
  input  logic            Reset_n,
  serial_rx_unit_if.slave rx
);
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] word_nxt;

  // Only the upper WIDTH-1 bits of the shifter are ever read back, so the
  // register keeps just those; the incoming bit completes the word.
  assign word_nxt = {rx.Sin, shreg};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx.Start)     state_nxt = SHIFT;
      SHIFT:   if (count == LAST) state_nxt = DONE;
      DONE:    if (!rx.Start)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count  <= '0;
      shreg  <= '0;
      dout_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx.Start) count  <= '0;
          if (rx.Clear) dout_r <= '0;
        end
        SHIFT: begin
          shreg <= word_nxt[WIDTH-1:1];
          if (count == LAST) begin
            count  <= '0;
            dout_r <= word_nxt;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx.Busy  = (state == SHIFT);
    rx.Valid = (state == DONE);
    rx.Dout  = dout_r;
  end
endmodule

// File: tb/tb_serial_rx_unit.sv
// Self-checking bench for serial_rx_unit: vector table, hand sequences and a
// completed-word scoreboard for an 8-bit and a 4-bit instance.
module tb_serial_rx_unit;
  logic Clk;
  logic Reset_n;

  serial_rx_unit_if #(.WIDTH(8)) b8 ();
  serial_rx_unit_if #(.WIDTH(4)) b4 ();

  serial_rx_unit #(.WIDTH(8)) dut8 (.Clk(Clk), .Reset_n(Reset_n), .rx(b8.slave));
  serial_rx_unit #(.WIDTH(4)) dut4 (.Clk(Clk), .Reset_n(Reset_n), .rx(b4.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       start;
    logic       sin;
    logic       clear;
    logic       busy;
    logic       valid;
    logic [7:0] dout;
  } vec_t;

  vec_t       vt [9];
  logic [7:0] sb8 [$];
  logic [3:0] sb4 [$];
  logic       prev_v8, prev_v4;
  int         n_tests, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, then compare any newly completed word with the scoreboard.
  task automatic tick();
    logic [7:0] e8;
    logic [3:0] e4;
    @(posedge Clk);
    #2;
    if (b8.Valid && !prev_v8) begin
      if (sb8.size() == 0) chk("sb8_unexpected_word", 32'(b8.Dout), 32'hDEAD);
      else begin
        e8 = sb8.pop_front();
        chk("sb8_word", 32'(b8.Dout), 32'(e8));
      end
    end
    if (b4.Valid && !prev_v4) begin
      if (sb4.size() == 0) chk("sb4_unexpected_word", 32'(b4.Dout), 32'hDEAD);
      else begin
        e4 = sb4.pop_front();
        chk("sb4_word", 32'(b4.Dout), 32'(e4));
      end
    end
    prev_v8 = b8.Valid;
    prev_v4 = b4.Valid;
  endtask

  task automatic send_frame8(input logic [7:0] w, input logic hold, input logic clr,
                             input logic [7:0] old_dout);
    sb8.push_back(w);
    b8.Start = 1'b1; b8.Clear = 1'b0;
    tick();
    chk("f8_busy_e0", 32'(b8.Busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      b8.Sin = w[i]; b8.Start = hold; b8.Clear = clr;
      tick();
      if (i < 7) begin
        chk("f8_busy_mid", 32'(b8.Busy), 32'd1);
        chk("f8_dout_hold", 32'(b8.Dout), 32'(old_dout));
      end else begin
        chk("f8_valid_end", 32'(b8.Valid), 32'd1);
        chk("f8_busy_end", 32'(b8.Busy), 32'd0);
        chk("f8_dout_end", 32'(b8.Dout), 32'(w));
      end
    end
    b8.Clear = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    logic [3:0] w4;
    n_tests = 0; n_fail = 0;
    prev_v8 = 1'b0; prev_v4 = 1'b0;

    // Main A5 frame, with Clear raised mid-shift (must be ignored).
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};

    // Asynchronous reset before the first clock edge.
    Reset_n = 1'b1;
    b8.Start = 1'($urandom); b8.Sin = 1'($urandom); b8.Clear = 1'($urandom);
    b4.Start = 1'($urandom); b4.Sin = 1'($urandom); b4.Clear = 1'($urandom);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_dout", 32'(b8.Dout), 32'd0);
    chk("rst_busy", 32'(b8.Busy), 32'd0);
    chk("rst_valid", 32'(b8.Valid), 32'd0);
    chk("rst_dout4", 32'(b4.Dout), 32'd0);
    tick(); tick();
    chk("rst_hold_busy", 32'(b8.Busy), 32'd0);
    b8.Start = 1'b0; b8.Sin = 1'b0; b8.Clear = 1'b0;
    b4.Start = 1'b0; b4.Sin = 1'b0; b4.Clear = 1'b0;
    Reset_n = 1'b1;
    tick();
    chk("idle_busy", 32'(b8.Busy), 32'd0);

    sb8.push_back(8'hA5);
    for (int i = 0; i < 9; i++) begin
      b8.Start = vt[i].start; b8.Sin = vt[i].sin; b8.Clear = vt[i].clear;
      tick();
      chk($sformatf("vec%0d_busy", i), 32'(b8.Busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d_valid", i), 32'(b8.Valid), 32'(vt[i].valid));
      chk($sformatf("vec%0d_dout", i), 32'(b8.Dout), 32'(vt[i].dout));
    end

    // Start held in DONE: no retrigger, Clear ignored.
    for (int i = 0; i < 20; i++) begin
      b8.Start = 1'b1; b8.Sin = 1'($urandom); b8.Clear = 1'(i % 2);
      tick();
      chk("hold_valid", 32'(b8.Valid), 32'd1);
      chk("hold_busy", 32'(b8.Busy), 32'd0);
      chk("hold_dout", 32'(b8.Dout), 32'hA5);
    end
    b8.Start = 1'b0; b8.Clear = 1'b0;
    tick();
    chk("rel_valid", 32'(b8.Valid), 32'd0);
    chk("rel_dout", 32'(b8.Dout), 32'hA5);

    send_frame8(8'h5A, 1'b1, 1'b1, 8'hA5);
    b8.Start = 1'b0;
    tick();
    chk("rel2_valid", 32'(b8.Valid), 32'd0);

    // Single-cycle Start pulse still captures a full frame.
    send_frame8(8'hFF, 1'b0, 1'b0, 8'h5A);
    tick();
    chk("pulse_idle_valid", 32'(b8.Valid), 32'd0);
    tick();
    chk("no_retrigger_busy", 32'(b8.Busy), 32'd0);

    // Reset after three bits discards the partial frame.
    w = 8'h3C;
    b8.Start = 1'b1;
    tick();
    b8.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b8.Sin = w[i];
      tick();
    end
    chk("pre_rst_busy", 32'(b8.Busy), 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(b8.Dout), 32'd0);
    chk("midrst_busy", 32'(b8.Busy), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(b8.Busy), 32'd0);
    send_frame8(8'h3C, 1'b0, 1'b0, 8'h00);
    tick();

    // Clear in IDLE, then Start and Clear together.
    b8.Clear = 1'b1;
    tick();
    chk("clr_idle_dout", 32'(b8.Dout), 32'd0);
    b8.Clear = 1'b0;
    send_frame8(8'h81, 1'b0, 1'b0, 8'h00);
    tick();
    w = 8'h66;
    sb8.push_back(w);
    b8.Start = 1'b1; b8.Clear = 1'b1;
    tick();
    chk("start_clr_dout", 32'(b8.Dout), 32'd0);
    chk("start_clr_busy", 32'(b8.Busy), 32'd1);
    b8.Start = 1'b0; b8.Clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b8.Sin = w[i];
      tick();
    end
    chk("f66_dout", 32'(b8.Dout), 32'h66);
    tick();

    // Four-bit instance: 1,1,0,1 -> 4'hB; Clear in DONE ignored, honoured in IDLE.
    w4 = 4'hB;
    sb4.push_back(w4);
    b4.Start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      b4.Sin = w4[i];
      tick();
      if (i < 3) chk("w4_busy", 32'(b4.Busy), 32'd1);
    end
    chk("w4_valid", 32'(b4.Valid), 32'd1);
    chk("w4_dout", 32'(b4.Dout), 32'hB);
    b4.Clear = 1'b1;
    tick();
    chk("w4_clr_done", 32'(b4.Dout), 32'hB);
    b4.Start = 1'b0;
    tick();
    chk("w4_clr_leave", 32'(b4.Dout), 32'hB);
    chk("w4_idle_valid", 32'(b4.Valid), 32'd0);
    tick();
    chk("w4_clr_idle", 32'(b4.Dout), 32'h0);
    b4.Clear = 1'b0;
    tick();

    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb4_drained", 32'(sb4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
